// File: rtl/ekf_stage_sched_pkg.sv
// Shared constants for the EKF stage scheduler and PE_config: opcodes,
// one-hot stage requests, stage status codes and error codes.
package ekf_stage_sched_pkg;

    localparam logic [1:0] OP_PRD = 2'b00;
    localparam logic [1:0] OP_NEW = 2'b01;
    localparam logic [1:0] OP_UPD = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [2:0] STAGE_PRD   = 3'b001;
    localparam logic [2:0] STAGE_NEW   = 3'b010;
    localparam logic [2:0] STAGE_UPD   = 3'b100;
    localparam logic [2:0] STAGE_BUSY  = 3'b000;
    localparam logic [2:0] STAGE_READY = 3'b111;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_FULL   = 2'd1;
    localparam logic [1:0] ERR_BAD_ID = 2'd2;
    localparam logic [1:0] ERR_FAIL   = 2'd3;

    function automatic logic [2:0] op_to_stage(input logic [1:0] op);
        case (op)
            OP_PRD:  op_to_stage = STAGE_PRD;
            OP_NEW:  op_to_stage = STAGE_NEW;
            OP_UPD:  op_to_stage = STAGE_UPD;
            default: op_to_stage = STAGE_BUSY;
        endcase
    endfunction

endpackage

// File: rtl/ekf_stage_sched_dim_calc.sv
// Combinational covariance dimension: landmark count -> rows (3 + 2*count)
// and lane groups (rows rounded up to a multiple of L, divided by L).
module ekf_dim_calc #(
    parameter int L         = 4,
    parameter int GROUP_LEN = 16
) (
    input  logic [GROUP_LEN-1:0] count,
    output logic [GROUP_LEN-1:0] cov_row_num,
    output logic [GROUP_LEN-1:0] group_num
);

    localparam int LOG2_L = $clog2(L);

    logic [GROUP_LEN-1:0] rows;

    assign rows        = GROUP_LEN'(3) + (count << 1);
    assign cov_row_num = rows;
    assign group_num   = (rows + GROUP_LEN'(L - 1)) >> LOG2_L;

endmodule

// File: rtl/ekf_stage_sched.sv
// EKF step scheduler: accepts PRD/NEW/UPD commands, issues one-hot stage_val to
// PE_config, tracks completion and the landmark count. Optional: STAGE_TIMEOUT_EN.
module ekf_stage_sched
    import ekf_stage_sched_pkg::*;
#(
    parameter int L              = 4,
    parameter int GROUP_LEN      = 16,
    parameter int MAX_LANDMARK   = 500,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 sys_rst,
    input  logic                 cmd_val,
    output logic                 cmd_rdy,
    input  logic [1:0]           cmd_op,
    input  logic [GROUP_LEN-1:0] cmd_lm_id,
    output logic [2:0]           stage_val,
    input  logic [2:0]           stage_rdy,
    output logic [GROUP_LEN-1:0] landmark_num,
    output logic [GROUP_LEN-1:0] cov_row_num,
    output logic [GROUP_LEN-1:0] group_num,
    output logic [GROUP_LEN-1:0] lm_count,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [1:0]           state_dbg
);

    // Command handshake: a command transfers on a rising edge where
    // cmd_val && cmd_rdy; cmd_rdy is only offered in IDLE with PE_config ready.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           state;
    logic [GROUP_LEN-1:0] count;
    logic [1:0]           op_q;
    logic                 err_q;
    logic [1:0]           code_q;
    logic [1:0]           chk_code;
    logic [GROUP_LEN-1:0] cov_next;
    logic [GROUP_LEN-1:0] grp_next;
    logic                 rdy_all;
    logic                 rdy_busy;
    logic                 accept;
    logic                 tmo_hit;

    assign rdy_all  = (stage_rdy == STAGE_READY);
    assign rdy_busy = (stage_rdy == STAGE_BUSY);
    assign cmd_rdy  = (state == S_IDLE) && rdy_all;
    assign accept   = cmd_val && cmd_rdy;

    ekf_dim_calc #(
        .L         (L),
        .GROUP_LEN (GROUP_LEN)
    ) u_dim_calc (
        .count       (count),
        .cov_row_num (cov_next),
        .group_num   (grp_next)
    );

    always_comb begin
        chk_code = ERR_NONE;
        case (cmd_op)
            OP_PRD: chk_code = ERR_NONE;
            OP_NEW: if (count == GROUP_LEN'(MAX_LANDMARK)) chk_code = ERR_FULL;
            OP_UPD: if (cmd_lm_id >= count) chk_code = ERR_BAD_ID;
            default: chk_code = ERR_FAIL;
        endcase
    end

`ifdef STAGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if ((state == S_ISSUE || state == S_WAIT) && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    // Without the watchdog the limit has no effect; this folds to constant 0.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= S_IDLE;
            count        <= '0;
            op_q         <= OP_PRD;
            err_q        <= 1'b0;
            code_q       <= ERR_NONE;
            landmark_num <= '0;
            cov_row_num  <= '0;
            group_num    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q        <= cmd_op;
                        err_q       <= (chk_code != ERR_NONE);
                        code_q      <= chk_code;
                        cov_row_num <= cov_next;
                        group_num   <= grp_next;
                        if (cmd_op == OP_NEW)      landmark_num <= count;
                        else if (cmd_op == OP_UPD) landmark_num <= cmd_lm_id;
                        else                       landmark_num <= '0;
                        // Rejected commands skip PE_config entirely.
                        state <= (chk_code != ERR_NONE) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (tmo_hit) begin
                        err_q  <= 1'b1;
                        code_q <= ERR_FAIL;
                        state  <= S_DONE;
                    end else if (rdy_busy) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tmo_hit) begin
                        err_q  <= 1'b1;
                        code_q <= ERR_FAIL;
                        state  <= S_DONE;
                    end else if (rdy_all) begin
                        // Count moves on the same edge that raises done.
                        if (op_q == OP_NEW) count <= count + GROUP_LEN'(1);
                        state <= S_DONE;
                    end
                end
                default: begin
                    err_q  <= 1'b0;
                    code_q <= ERR_NONE;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign stage_val = (state == S_ISSUE) ? op_to_stage(op_q) : STAGE_BUSY;
    assign done      = (state == S_DONE);
    assign err       = done && err_q;
    assign err_code  = done ? code_q : ERR_NONE;
    assign lm_count  = count;
    assign state_dbg = state;

endmodule

// File: tb/tb_ekf_stage_sched.sv
// Self-checking bench for ekf_stage_sched: scripted and random commands, a
// PE_config responder inside the driver, and a done-result scoreboard.
module tb_ekf_stage_sched;
    import ekf_stage_sched_pkg::*;

    localparam int GL = 16;
    localparam int W  = GL + 3;

    logic          clk = 1'b0;
    logic          sys_rst;
    logic          cmd_val;
    logic          cmd_rdy;
    logic [1:0]    cmd_op;
    logic [GL-1:0] cmd_lm_id;
    logic [2:0]    stage_val;
    logic [2:0]    stage_rdy;
    logic [GL-1:0] landmark_num;
    logic [GL-1:0] cov_row_num;
    logic [GL-1:0] group_num;
    logic [GL-1:0] lm_count;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [1:0]    state_dbg;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            m_count = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  e;

    ekf_stage_sched #(
        .L              (4),
        .GROUP_LEN      (GL),
        .MAX_LANDMARK   (500),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk          (clk),
        .sys_rst      (sys_rst),
        .cmd_val      (cmd_val),
        .cmd_rdy      (cmd_rdy),
        .cmd_op       (cmd_op),
        .cmd_lm_id    (cmd_lm_id),
        .stage_val    (stage_val),
        .stage_rdy    (stage_rdy),
        .landmark_num (landmark_num),
        .cov_row_num  (cov_row_num),
        .group_num    (group_num),
        .lm_count     (lm_count),
        .done         (done),
        .err          (err),
        .err_code     (err_code),
        .state_dbg    (state_dbg)
    );

    // Clock and reset
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every done pulse consumes one expected {err, err_code, lm_count}.
    always @(negedge clk) begin
        if (sys_rst === 1'b0 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("done_unexpected", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check_eq("done_err", err, e[W-1]);
                check_eq("done_code", err_code, e[W-2 -: 2]);
                check_eq("done_lm_count", lm_count, e[GL-1:0]);
            end
        end
    end

    function automatic logic [1:0] model_code(input logic [1:0] op, input int id);
        case (op)
            OP_PRD:  model_code = 2'd0;
            OP_NEW:  model_code = (m_count == 500) ? 2'd1 : 2'd0;
            OP_UPD:  model_code = (id >= m_count) ? 2'd2 : 2'd0;
            default: model_code = 2'd3;
        endcase
    endfunction

    // Drive a command and return at the negedge of cycle T+1.
    task automatic handshake(input logic [1:0] op, input int id);
        int cyc;
        @(negedge clk);
        cmd_val   = 1'b1;
        cmd_op    = op;
        cmd_lm_id = GL'(id);
        cyc = 0;
        while (cmd_rdy !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc == 50) check_eq("cmd_rdy_wait", cmd_rdy, 1);
        @(negedge clk);
        cmd_val = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input int id, input int hold111, input int busy_n);
        logic [1:0] code;
        logic [2:0] exp_sv;
        int         inc;
        int         cyc;
        int         exp_cov;
        code = model_code(op, id);
        inc  = (op == OP_NEW && code == 2'd0) ? 1 : 0;
        exp_q.push_back({code != 2'd0, code, 16'(m_count + inc)});
        handshake(op, id);
        if (code != 2'd0) begin
            check_eq("err_stage_val", stage_val, 0);
            check_eq("err_done_t1", done, 1);
            check_eq("err_cmd_rdy", cmd_rdy, 0);
        end else begin
            exp_sv  = (op == OP_PRD) ? 3'b001 : (op == OP_NEW) ? 3'b010 : 3'b100;
            exp_cov = 3 + 2 * m_count;
            check_eq("issue_stage_val", stage_val, exp_sv);
            check_eq("issue_landmark", landmark_num, (op == OP_NEW) ? m_count : (op == OP_UPD) ? id : 0);
            check_eq("issue_cov_rows", cov_row_num, exp_cov);
            check_eq("issue_groups", group_num, (exp_cov + 3) / 4);
            check_eq("issue_cmd_rdy", cmd_rdy, 0);
            check_eq("issue_err_idle", {err, err_code}, 0);
            for (int i = 0; i < hold111; i++) begin
                @(negedge clk);
                check_eq("held_stage_val", stage_val, exp_sv);
            end
            stage_rdy = STAGE_BUSY;
            @(negedge clk);
            check_eq("drop_stage_val", stage_val, 0);
            check_eq("wait_done_low", done, 0);
            for (int i = 1; i < busy_n; i++) @(negedge clk);
            stage_rdy = STAGE_READY;
            @(negedge clk);
            check_eq("done_after_rdy", done, 1);
            cyc = 0;
            while (done !== 1'b1 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            m_count += inc;
        end
        @(negedge clk);
        check_eq("done_pulse_len", done, 0);
        check_eq("rdy_after_done", cmd_rdy, 1);
    endtask

    initial begin
        sys_rst   = 1'b1;
        cmd_val   = 1'b0;
        cmd_op    = OP_PRD;
        cmd_lm_id = '0;
        stage_rdy = STAGE_BUSY;
        repeat (3) @(negedge clk);
        check_eq("rst_stage_val", stage_val, 0);
        check_eq("rst_cmd_rdy", cmd_rdy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", {err, err_code}, 0);
        check_eq("rst_lm_count", lm_count, 0);
        check_eq("rst_operands", {landmark_num, cov_row_num}, 0);
        check_eq("rst_groups", group_num, 0);
        check_eq("rst_state", state_dbg, 0);
        sys_rst = 1'b0;
        @(negedge clk);
        check_eq("idle_busy_rdy", cmd_rdy, 0);
        stage_rdy = STAGE_READY;
        @(negedge clk);
        check_eq("idle_ready_rdy", cmd_rdy, 1);

        run_cmd(OP_PRD, 0, 0, 1);
        run_cmd(OP_NEW, 0, 0, 2);
        run_cmd(OP_NEW, 0, 3, 1);
        run_cmd(OP_NEW, 0, 0, 3);
        check_eq("count_after_3_new", lm_count, 3);
        run_cmd(OP_UPD, 3, 0, 1);
        run_cmd(OP_UPD, 1, 1, 2);
        run_cmd(OP_ILL, 0, 0, 1);

        for (int k = 0; k < 10; k++) begin
            run_cmd(2'($urandom_range(0, 2)), $urandom_range(0, m_count + 1),
                    $urandom_range(0, 2), $urandom_range(1, 3));
        end

        // Async reset in the middle of WAIT; no done may follow.
        handshake(OP_PRD, 0);
        stage_rdy = STAGE_BUSY;
        @(negedge clk);
        @(negedge clk);
        check_eq("pre_rst_state", state_dbg, 2);
        #2 sys_rst = 1'b1;
        #1;
        check_eq("mid_rst_stage_val", stage_val, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_err", {err, err_code}, 0);
        check_eq("mid_rst_lm_count", lm_count, 0);
        check_eq("mid_rst_operands", {landmark_num, cov_row_num}, 0);
        check_eq("mid_rst_groups", group_num, 0);
        check_eq("mid_rst_state", state_dbg, 0);
        @(negedge clk);
        sys_rst   = 1'b0;
        stage_rdy = STAGE_READY;
        m_count   = 0;

        for (int k = 0; k < 500; k++) run_cmd(OP_NEW, 0, 0, 1);
        check_eq("count_full", lm_count, 500);
        run_cmd(OP_NEW, 0, 0, 1);
        check_eq("count_stays_full", lm_count, 500);
        run_cmd(OP_PRD, 0, 0, 1);
        check_eq("cov_at_max", cov_row_num, 1003);
        check_eq("groups_at_max", group_num, 251);
        run_cmd(OP_UPD, 499, 0, 2);
        run_cmd(OP_UPD, 500, 0, 1);

`ifdef STAGE_TIMEOUT_EN
        begin
            int cyc;
            exp_q.push_back({1'b1, 2'd3, 16'(m_count)});
            handshake(OP_PRD, 0);
            stage_rdy = STAGE_BUSY;
            cyc = 0;
            while (done !== 1'b1 && cyc < 40) begin
                cyc++;
                @(negedge clk);
            end
            check_eq("timeout_cycles", cyc, 10);
            check_eq("timeout_stage_val", stage_val, 0);
            stage_rdy = STAGE_READY;
            @(negedge clk);
            check_eq("timeout_done_pulse", done, 0);
            check_eq("timeout_count", lm_count, m_count);
        end
`endif

        repeat (3) @(negedge clk);
        check_eq("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
